board_line_scanner: RTL

Sequential front-end for the connect-4 win checker. On a `start` pulse it snapshots the full board, then presents one padded line of cells per clock: every row, column and both diagonal directions long enough to hold a win. It accumulates the checker's per-line `winner` response and reports the game result (P1/P2 win or draw) with a one-cycle `done` pulse.

---
 rtl/connect4_pkg.sv | 26 ++
 rtl/board_line_scanner_line_select.sv | 57 +++++
 rtl/board_line_scanner.sv | 119 +++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared constants, cell encoding and scan state for the connect-4 board scanner.
// Line geometry derives from ROWS/COLS/CONN; LINE_W is the checker width.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CONN    = 4;
  localparam int LINE_W  = (ROWS > COLS) ? ROWS : COLS;
  localparam int NDIAG   = ROWS + COLS - 2*CONN + 1;
  localparam int NLINES  = ROWS + COLS + 2*NDIAG;
  localparam int IDX_W   = 5;
  localparam int BOARD_W = 2*ROWS*COLS;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef logic [2*LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/board_line_scanner_line_select.sv
// Combinational line picker: board + line index -> padded LINE_W-cell line.
// Order: rows, columns, rising diagonals, falling diagonals; out-of-range is 00.
module line_select
  import connect4_pkg::*;
(
  input  logic [BOARD_W-1:0] i_board,
  input  logic [IDX_W-1:0]   i_index,
  output line_t              o_line
);

  function automatic logic [1:0] cell_at(
    input logic [BOARD_W-1:0] b,
    input int                 r,
    input int                 c
  );
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS)
      return CELL_EMPTY;
    return b[2*(r*COLS+c) +: 2];
  endfunction

  // Cells that fall off the board become 00, which yields the padding.
  function automatic line_t pick(
    input logic [BOARD_W-1:0] b,
    input logic [IDX_W-1:0]   idx
  );
    line_t l;
    int    k;
    int    d;
    int    r0;
    int    c0;
    l  = '0;
    k  = int'(idx);
    d  = 0;
    r0 = 0;
    c0 = 0;
    for (int s = 0; s < LINE_W; s++) begin
      if (k < ROWS) begin
        l[2*s +: 2] = cell_at(b, k, s);
      end else if (k < ROWS + COLS) begin
        l[2*s +: 2] = cell_at(b, s, k - ROWS);
      end else if (k < ROWS + COLS + NDIAG) begin
        d  = k - ROWS - COLS - (ROWS - CONN);
        r0 = (d < 0) ? -d : 0;
        c0 = (d > 0) ? d : 0;
        l[2*s +: 2] = cell_at(b, r0 + s, c0 + s);
      end else if (k < NLINES) begin
        d  = k - ROWS - COLS - NDIAG + CONN - 1;
        c0 = (d > ROWS - 1) ? d - (ROWS - 1) : 0;
        l[2*s +: 2] = cell_at(b, d - (c0 + s), c0 + s);
      end
    end
    return l;
  endfunction

  assign o_line = pick(i_board, i_index);

endmodule

// File: rtl/board_line_scanner.sv
// Snapshots the board on start, streams one padded line per clock to the checker.
// SCAN_EARLY_EXIT_EN: stop scanning on the first line the checker reports a win.
module board_line_scanner
  import connect4_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [BOARD_W-1:0]  board,
  output logic [2*LINE_W-1:0] line_cells,
  input  logic [1:0]          line_winner,
  output logic [IDX_W-1:0]    line_index,
  output logic                busy,
  output logic                done,
  output logic [1:0]          winner,
  output logic                draw
);

  scan_state_t           r_state;
  logic [BOARD_W-1:0]    r_snap;
  logic [1:0]            r_acc;
  logic [2*LINE_W-1:0]   r_line_cells;
  logic [IDX_W-1:0]      r_line_index;
  logic                  r_busy;
  logic                  r_done;
  logic [1:0]            r_winner;
  logic                  r_draw;

  logic [BOARD_W-1:0]    w_sel_board;
  logic [IDX_W-1:0]      w_sel_idx;
  line_t                 w_line;
  logic [1:0]            w_acc_next;
  logic                  w_last;
  logic                  w_hit;
  logic                  w_full;

  // In IDLE the next line is line 0 of the live board, so it is ready
  // in the first SCAN cycle alongside the snapshot.
  assign w_sel_board = (r_state == S_IDLE) ? board : r_snap;
  assign w_sel_idx   = (r_state == S_IDLE) ? '0 : r_line_index + 1'b1;

  line_select u_line_select (
    .i_board (w_sel_board),
    .i_index (w_sel_idx),
    .o_line  (w_line)
  );

  assign w_acc_next = r_acc | line_winner;
  assign w_last     = (r_line_index == IDX_W'(NLINES - 1));

`ifdef SCAN_EARLY_EXIT_EN
  assign w_hit = |line_winner;
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (r_snap[2*i +: 2] == CELL_EMPTY)
        w_full = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_acc        <= '0;
      r_line_cells <= '0;
      r_line_index <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_winner     <= '0;
      r_draw       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap       <= board;
            r_acc        <= '0;
            r_line_index <= '0;
            r_line_cells <= w_line;
            r_busy       <= 1'b1;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_acc <= w_acc_next;
          if (w_last || w_hit) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_winner <= w_acc_next;
            r_draw   <= w_full & (w_acc_next == 2'b00);
            r_state  <= S_DONE;
          end else begin
            r_line_index <= r_line_index + 1'b1;
            r_line_cells <= w_line;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign line_cells = r_line_cells;
  assign line_index = r_line_index;
  assign busy       = r_busy;
  assign done       = r_done;
  assign winner     = r_winner;
  assign draw       = r_draw;

endmodule
